// File: rtl/ecc_core_arbiter.sv
// rtl/ecc_core_arbiter.sv - Round-robin arbiter sharing one double_and_add core among NREQ requesters
// Latches the granted job's operands, pulses the core reset, waits for done under a watchdog, returns kP.
module ecc_core_arbiter #(
    parameter int n        = 193,
    parameter int NREQ     = 4,
    parameter int LOAD_CYC = 2,
    parameter int TIMEOUT  = 2000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*n-1:0] req_p,
    input  logic [NREQ*n-1:0] req_a,
    input  logic [NREQ*n-1:0] req_k,
    input  logic [NREQ*n-1:0] req_x,
    input  logic [NREQ*n-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_id,
    output logic [n-1:0]      rsp_x,
    output logic [n-1:0]      rsp_y,
    output logic              rsp_timeout,
    output logic              core_reset,
    output logic [n-1:0]      core_p,
    output logic [n-1:0]      core_a,
    output logic [n-1:0]      core_c,
    output logic [n-1:0]      core_x1,
    output logic [n-1:0]      core_y1,
    input  logic [n-1:0]      core_x3,
    input  logic [n-1:0]      core_y3,
    input  logic              core_done
);

    localparam int CMAX = (TIMEOUT > LOAD_CYC) ? TIMEOUT : LOAD_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] LD_LAST = CW'(LOAD_CYC - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, RESP} state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      rr_ptr;
    logic [2:0]      gnt_idx;
    logic [IW-1:0]   cand;
    logic [NREQ-1:0] gnt_oh;
    logic            gnt_found;
    logic [n-1:0]    sel_p;
    logic [n-1:0]    sel_a;
    logic [n-1:0]    sel_k;
    logic [n-1:0]    sel_x;
    logic [n-1:0]    sel_y;
    logic            run_done;
    logic            run_tmo;

    // Search order starts just past the last winner, so every requester waits at most NREQ-1 jobs.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        cand      = '0;
        for (int o = 1; o <= NREQ; o++) begin
            cand = IW'((int'(rr_ptr) + o) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found    = 1'b1;
                gnt_idx      = 3'(cand);
                gnt_oh[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_p = '0;
        sel_a = '0;
        sel_k = '0;
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == 3'(i)) begin
                sel_p = req_p[i*n +: n];
                sel_a = req_a[i*n +: n];
                sel_k = req_k[i*n +: n];
                sel_x = req_x[i*n +: n];
                sel_y = req_y[i*n +: n];
            end
        end
    end

    // The first RUN cycle can still see done left over from the previous job.
    assign run_done = (state == RUN) && core_done && (cnt != '0);
    assign run_tmo  = (state == RUN) && !run_done && (cnt == TO_LAST);

    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        core_reset = 1'b1;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    req_ready = reset ? '0 : gnt_oh;
                    state_nx  = LOAD;
                end
            end
            LOAD: begin
                if (cnt == LD_LAST) state_nx = RUN;
            end
            RUN: begin
                core_reset = 1'b0;
                if (run_done)     state_nx = CAPT;
                else if (run_tmo) state_nx = RESP;
            end
            CAPT: begin
                core_reset = 1'b0;
                state_nx   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= 3'(NREQ - 1);
            cnt         <= '0;
            rsp_id      <= '0;
            rsp_x       <= '0;
            rsp_y       <= '0;
            rsp_timeout <= 1'b0;
            core_p      <= '0;
            core_a      <= '0;
            core_c      <= '0;
            core_x1     <= '0;
            core_y1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        rr_ptr  <= gnt_idx;
                        rsp_id  <= gnt_idx;
                        core_p  <= sel_p;
                        core_a  <= sel_a;
                        core_c  <= sel_k;
                        core_x1 <= sel_x;
                        core_y1 <= sel_y;
                        cnt     <= '0;
                    end
                end
                LOAD: begin
                    cnt <= (cnt == LD_LAST) ? '0 : cnt + CW'(1);
                end
                RUN: begin
                    if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
                    if (run_tmo) begin
                        rsp_timeout <= 1'b1;
                        rsp_x       <= '0;
                        rsp_y       <= '0;
                    end
                end
                CAPT: begin
                    rsp_x       <= core_x3;
                    rsp_y       <= core_y3;
                    rsp_timeout <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_core_arbiter.sv
// tb/tb_ecc_core_arbiter.sv - Table-driven bench for ecc_core_arbiter
// A behavioural core answers kx=x1+c, ky=y1^c, with a transient value until one cycle after done.
module tb_ecc_core_arbiter;

    localparam int N        = 193;
    localparam int NREQ     = 4;
    localparam int LOAD_CYC = 2;
    localparam int TIMEOUT  = 100;
    localparam int NVEC     = 14;

    localparam logic [N-1:0] P192 = 193'hfffffffffffffffffffffffffffffffeffffffffffffffff;
    localparam logic [N-1:0] A192 = 193'hfffffffffffffffffffffffffffffffefffffffffffffffc;
    localparam logic [N-1:0] GX   = 193'hd458e7d127ae671b0c330266d246769353a012073e97acf8;
    localparam logic [N-1:0] GY   = 193'h325930500d851f336bddc050cf7fb11b5673a1645086df3b;

    typedef struct {
        logic [NREQ-1:0] mask;
        int              lat;
        bit              never;
        bit              stale;
        int              hold;
        logic [N-1:0]    k;
        logic [N-1:0]    x;
        logic [N-1:0]    y;
        int              expg;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*N-1:0] req_p, req_a, req_k, req_x, req_y;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [2:0]      rsp_id;
    logic [N-1:0]    rsp_x, rsp_y;
    logic            rsp_timeout;
    logic            core_reset;
    logic [N-1:0]    core_p, core_a, core_c, core_x1, core_y1, core_x3, core_y3;
    logic            core_done;

    int   tests = 0;
    int   fails = 0;
    vec_t tbl[NVEC];

    int   m_lat   = 3;
    bit   m_never = 1'b0;
    bit   m_stale = 1'b0;
    int   run_cnt = 0;
    logic [N-1:0] fin_x, fin_y;

    always #5 clk = ~clk;

    ecc_core_arbiter #(.n(N), .NREQ(NREQ), .LOAD_CYC(LOAD_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_p(req_p), .req_a(req_a), .req_k(req_k), .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_timeout(rsp_timeout),
        .core_reset(core_reset),
        .core_p(core_p), .core_a(core_a), .core_c(core_c), .core_x1(core_x1), .core_y1(core_y1),
        .core_x3(core_x3), .core_y3(core_y3), .core_done(core_done)
    );

    always @(negedge clk) begin
        if (core_reset === 1'b0) begin
            run_cnt++;
            core_done = (m_stale && run_cnt == 1) || (!m_never && run_cnt >= m_lat);
        end else begin
            run_cnt   = 0;
            core_done = m_stale;
        end
        fin_x   = core_x1 + core_c;
        fin_y   = core_y1 ^ core_c;
        core_x3 = (run_cnt > m_lat) ? fin_x : ~fin_x;
        core_y3 = (run_cnt > m_lat) ? fin_y : ~fin_y;
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    function automatic vec_t mk(logic [NREQ-1:0] m, int lat, bit nv, bit st, int hold,
                                logic [N-1:0] k, logic [N-1:0] x, logic [N-1:0] y, int g);
        vec_t v;
        v.mask = m; v.lat = lat; v.never = nv; v.stale = st; v.hold = hold;
        v.k = k; v.x = x; v.y = y; v.expg = g;
        return v;
    endfunction

    task automatic do_job(input int t, input vec_t e);
        int c, ld, lat, exp_lat;
        logic [N-1:0] kk, xx, yy, ex, ey;
        logic bad;
        for (int i = 0; i < NREQ; i++) begin
            req_p[i*N +: N] = P192 + N'(i);
            req_a[i*N +: N] = A192 + N'(i);
            req_k[i*N +: N] = e.k + N'(i);
            req_x[i*N +: N] = e.x + N'(i);
            req_y[i*N +: N] = e.y + N'(i);
        end
        req_valid = e.mask;
        m_lat     = e.lat;
        m_never   = e.never;
        m_stale   = e.stale;
        #1;
        c = 0;
        while (req_ready == '0 && c < 20) begin
            step();
            c++;
        end
        chk($sformatf("grant%0d", t), N'(req_ready), N'(1) << e.expg);
        if (req_ready == '0) return;
        chk($sformatf("idle_rsp_valid%0d", t), N'(rsp_valid), N'(0));
        rsp_ready = (e.hold == 0);
        kk = e.k + N'(e.expg);
        xx = e.x + N'(e.expg);
        yy = e.y + N'(e.expg);
        step();
        chk($sformatf("pulse%0d", t), N'(req_ready), N'(0));
        chk($sformatf("core_c%0d", t), core_c, kk);
        chk($sformatf("core_x1_%0d", t), core_x1, xx);
        chk($sformatf("core_p%0d", t), core_p, P192 + N'(e.expg));
        lat = 0;
        ld  = -1;
        for (c = 1; c < 400; c++) begin
            if (ld < 0 && core_reset == 1'b0) ld = c - 1;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            step();
        end
        exp_lat = e.never ? LOAD_CYC + TIMEOUT + 1 : LOAD_CYC + ((e.lat < 2) ? 2 : e.lat) + 2;
        chk($sformatf("load_cycles%0d", t), N'(ld), N'(LOAD_CYC));
        chk($sformatf("latency%0d", t), N'(lat), N'(exp_lat));
        if (lat == 0) return;
        ex = e.never ? '0 : xx + kk;
        ey = e.never ? '0 : yy ^ kk;
        bad = 1'b0;
        for (int h = 0; h < e.hold; h++) begin
            if (rsp_valid !== 1'b1 || rsp_x !== ex || rsp_y !== ey || rsp_id !== 3'(e.expg) ||
                core_reset !== 1'b1 || req_ready !== '0)
                bad = 1'b1;
            step();
        end
        if (e.hold > 0) begin
            chk($sformatf("backpressure%0d", t), N'(bad), N'(0));
            rsp_ready = 1'b1;
            #1;
        end
        chk($sformatf("rsp_valid%0d", t), N'(rsp_valid), N'(1));
        chk($sformatf("rsp_id%0d", t), N'(rsp_id), N'(e.expg));
        chk($sformatf("rsp_x%0d", t), rsp_x, ex);
        chk($sformatf("rsp_y%0d", t), rsp_y, ey);
        chk($sformatf("rsp_timeout%0d", t), N'(rsp_timeout), N'(e.never));
        chk($sformatf("hs_ready%0d", t), N'(req_ready), N'(0));
    endtask

    initial begin
        int lats[8];
        int c;
        lats = '{3, 3, 4, 3, 2, 3, 1, 3};
        for (int t = 0; t < 8; t++)
            tbl[t] = mk(4'hf, lats[t], 1'b0, 1'b0, 0, N'(7 + t), GX + N'(t * 11), GY + N'(t * 13), t % 4);
        tbl[8]  = mk(4'h1, 5,  1'b0, 1'b0, 0,  N'(2),  GX, GY, 0);
        tbl[9]  = mk(4'h4, 5,  1'b1, 1'b0, 0,  N'(9),  GX, GY, 2);
        tbl[10] = mk(4'ha, 4,  1'b0, 1'b0, 0,  N'(33), GY, GX, 3);
        tbl[11] = mk(4'hf, 20, 1'b0, 1'b1, 0,  N'(21), GX, GY, 0);
        tbl[12] = mk(4'hf, 6,  1'b0, 1'b0, 50, N'(77), GY, GX, 1);
        tbl[13] = mk(4'h1, 3,  1'b0, 1'b0, 0,  N'(5),  GX, GY, 0);

        req_p = '0; req_a = '0; req_k = '0; req_x = '0; req_y = '0;
        do_reset();
        chk("reset_rsp_valid", N'(rsp_valid), N'(0));
        chk("reset_rsp_timeout", N'(rsp_timeout), N'(0));
        chk("reset_rsp_id", N'(rsp_id), N'(0));
        chk("reset_rsp_x", rsp_x, N'(0));
        chk("reset_core_reset", N'(core_reset), N'(1));
        chk("reset_core_p", core_p, N'(0));
        chk("reset_req_ready", N'(req_ready), N'(0));

        for (int t = 0; t < NVEC; t++) do_job(t, tbl[t]);

        do_reset();
        m_lat = 1000; m_never = 1'b1; m_stale = 1'b0;
        req_valid = 4'h4;
        #1;
        c = 0;
        while (req_ready == '0 && c < 20) begin step(); c++; end
        c = 0;
        while (core_reset !== 1'b0 && c < 20) begin step(); c++; end
        chk("midrun_entered", N'(core_reset), N'(0));
        repeat (10) step();
        req_valid = 4'hf;
        reset = 1'b1;
        #1;
        chk("midrun_core_reset", N'(core_reset), N'(1));
        chk("midrun_rsp_valid", N'(rsp_valid), N'(0));
        chk("midrun_req_ready", N'(req_ready), N'(0));
        chk("midrun_rsp_id", N'(rsp_id), N'(0));
        chk("midrun_core_c", core_c, N'(0));
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rr_after_reset", N'(req_ready), N'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit 200000", $time);
        $fatal(1);
    end

endmodule
